// File: rtl/oven_pkg.sv
// Shared definitions for the oven plant: state encoding and default timing/stock values.
package oven_pkg;

  typedef logic [2:0] oven_state_t;

  localparam oven_state_t ST_COLD    = 3'd0;
  localparam oven_state_t ST_WARMING = 3'd1;
  localparam oven_state_t ST_HOT     = 3'd2;
  localparam oven_state_t ST_COOKING = 3'd3;
  localparam oven_state_t ST_READY   = 3'd4;

  localparam int PREHEAT_CYCLES_DEF = 16;
  localparam int COOK_CYCLES_DEF    = 32;
  localparam int STOCK_INIT_DEF     = 8;

endpackage

// File: rtl/oven_cycle_timer.sv
// 8-bit cycle counter: clear wins over enable; tc flags the counter sitting at the terminal value.
module oven_cycle_timer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] term,
  output logic       tc
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/oven_plant.sv
// Oven plant: preheat / cook sequencing, portion stock and sticky protocol-fault flag.
//   state   | meaning
//   COLD    | heater off, waiting for heat
//   WARMING | heater on, preheat timer running
//   HOT     | at temperature, can accept a load
//   COOKING | portion in heater, cook timer running
//   READY   | portion cooked, waiting for unload
module oven_plant
  import oven_pkg::*;
#(
  parameter int PREHEAT_CYCLES = PREHEAT_CYCLES_DEF,
  parameter int COOK_CYCLES    = COOK_CYCLES_DEF,
  parameter int STOCK_INIT     = STOCK_INIT_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       heat,
  input  logic       load,
  input  logic       unload,
  input  logic       refill,
  input  logic       fault_clr,
  output logic       temp_ok,
  output logic       done,
  output logic       food_out,
  output logic [3:0] stock,
  output logic       empty,
  output logic       fault
);

  localparam logic [7:0] PRE_TERM   = 8'(PREHEAT_CYCLES - 1);
  localparam logic [7:0] COOK_TERM  = 8'(COOK_CYCLES - 1);
  localparam logic [3:0] STOCK_FULL = 4'(STOCK_INIT);

  oven_state_t state_q, state_d;
  logic [3:0]  stock_q, stock_d, stock_avail;
  logic        fault_q, fault_d, fault_set;
  logic        food_out_q, food_out_d;
  logic        load_ok;
  logic        pre_clear, pre_tc, cook_clear, cook_tc;

  // Timers only run while their state is active with heat held; anything else zeroes them.
  assign pre_clear  = (state_q != ST_WARMING) || !heat;
  assign cook_clear = (state_q != ST_COOKING) || !heat;

  oven_cycle_timer u_preheat_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (pre_clear),
    .enable  (heat),
    .term    (PRE_TERM),
    .tc      (pre_tc)
  );

  oven_cycle_timer u_cook_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (cook_clear),
    .enable  (heat),
    .term    (COOK_TERM),
    .tc      (cook_tc)
  );

  always_comb begin
    state_d     = state_q;
    fault_set   = 1'b0;
    load_ok     = 1'b0;
    food_out_d  = 1'b0;
    stock_avail = refill ? STOCK_FULL : stock_q;

    case (state_q)
      ST_COLD: begin
        if (heat) state_d = ST_WARMING;
      end
      ST_WARMING: begin
        if (!heat)       state_d = ST_COLD;
        else if (pre_tc) state_d = ST_HOT;
      end
      ST_HOT: begin
        // Losing heat takes precedence over a same-cycle load.
        if (!heat) begin
          state_d = ST_COLD;
        end else if (load) begin
          if (stock_avail != 4'd0) begin
            load_ok = 1'b1;
            state_d = ST_COOKING;
          end else begin
            fault_set = 1'b1;
          end
        end
      end
      ST_COOKING: begin
        if (!heat) begin
          fault_set = 1'b1;
          state_d   = ST_COLD;
        end else if (cook_tc) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (unload) begin
          food_out_d = 1'b1;
          state_d    = heat ? ST_HOT : ST_COLD;
        end
      end
      default: state_d = ST_COLD;
    endcase

    if (load && (state_q != ST_HOT))     fault_set = 1'b1;
    if (unload && (state_q != ST_READY)) fault_set = 1'b1;

    stock_d = load_ok ? (stock_avail - 4'd1) : stock_avail;

    if (fault_set)      fault_d = 1'b1;
    else if (fault_clr) fault_d = 1'b0;
    else                fault_d = fault_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_COLD;
      stock_q    <= STOCK_FULL;
      fault_q    <= 1'b0;
      food_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stock_q    <= stock_d;
      fault_q    <= fault_d;
      food_out_q <= food_out_d;
    end
  end

  assign temp_ok  = (state_q == ST_HOT) || (state_q == ST_COOKING);
  assign done     = (state_q == ST_READY);
  assign food_out = food_out_q;
  assign stock    = stock_q;
  assign empty    = (stock_q == 4'd0);
  assign fault    = fault_q;

endmodule

// File: tb/tb_oven_plant.sv
// Bench for oven_plant: behavioural plant model checked every cycle, plus directed literal checks.
module tb_oven_plant;

  localparam int PRE  = 4;
  localparam int COOK = 6;
  localparam int STK  = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       heat = 1'b0, load = 1'b0, unload = 1'b0, refill = 1'b0, fault_clr = 1'b0;
  logic       temp_ok, done, food_out, empty, fault;
  logic [3:0] stock;

  int n_checks = 0;
  int n_fail   = 0;

  oven_plant #(
    .PREHEAT_CYCLES (PRE),
    .COOK_CYCLES    (COOK),
    .STOCK_INIT     (STK)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .heat      (heat),
    .load      (load),
    .unload    (unload),
    .refill    (refill),
    .fault_clr (fault_clr),
    .temp_ok   (temp_ok),
    .done      (done),
    .food_out  (food_out),
    .stock     (stock),
    .empty     (empty),
    .fault     (fault)
  );

  always #5 clock = ~clock;

  // Plant seen as activities with elapsed-time counters rather than an encoded state.
  typedef struct {
    bit warming, hot, cooking, ready, food, fault;
    int heat_age, cook_age, stock;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.warming = 0; r.hot = 0; r.cooking = 0; r.ready = 0; r.food = 0; r.fault = 0;
    r.heat_age = 0; r.cook_age = 0; r.stock = STK;
    return r;
  endfunction

  function automatic model_t model_step(model_t p, bit h, bit l, bit u, bit r, bit fc);
    model_t n = p;
    bit viol = 0;
    n.food  = 0;
    n.stock = r ? STK : p.stock;
    if (p.ready) begin
      if (l) viol = 1;
      if (u) begin n.food = 1; n.ready = 0; n.hot = h; end
    end else if (p.cooking) begin
      if (l || u) viol = 1;
      if (!h) begin viol = 1; n.cooking = 0; end
      else begin
        n.cook_age = p.cook_age + 1;
        if (n.cook_age == COOK) begin n.cooking = 0; n.ready = 1; end
      end
    end else if (p.hot) begin
      if (u) viol = 1;
      if (!h) n.hot = 0;
      else if (l) begin
        if (n.stock > 0) begin
          n.stock = n.stock - 1; n.hot = 0; n.cooking = 1; n.cook_age = 0;
        end else viol = 1;
      end
    end else if (p.warming) begin
      if (l || u) viol = 1;
      if (!h) n.warming = 0;
      else begin
        n.heat_age = p.heat_age + 1;
        if (n.heat_age == PRE) begin n.warming = 0; n.hot = 1; end
      end
    end else begin
      if (l || u) viol = 1;
      if (h) begin n.warming = 1; n.heat_age = 0; end
    end
    n.fault = viol ? 1'b1 : (fc ? 1'b0 : p.fault);
    return n;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m <= model_reset();
    else          m <= model_step(m, heat, load, unload, refill, fault_clr);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      chk("model_temp_ok", int'(temp_ok), int'(m.hot || m.cooking));
      chk("model_done", int'(done), int'(m.ready));
      chk("model_food_out", int'(food_out), int'(m.food));
      chk("model_stock", int'(stock), m.stock);
      chk("model_empty", int'(empty), int'(m.stock == 0));
      chk("model_fault", int'(fault), int'(m.fault));
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    heat = 0; load = 0; unload = 0; refill = 0; fault_clr = 0;
    @(negedge clock);
    chk("rst_temp_ok", int'(temp_ok), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_food_out", int'(food_out), 0);
    chk("rst_empty", int'(empty), 0);
    chk("rst_stock", int'(stock), STK);
    chk("rst_fault", int'(fault), 0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic wait_for(input string name, input bit want_done);
    for (int i = 0; i < 60; i++) begin
      if (want_done ? done : temp_ok) break;
      @(negedge clock);
    end
    chk(name, int'(want_done ? done : temp_ok), 1);
  endtask

  task automatic full_cycle(input bit keep_heat);
    heat = 1;
    wait_for("wait_temp_ok", 1'b0);
    load = 1;
    @(negedge clock);
    load = 0;
    wait_for("wait_done", 1'b1);
    unload = 1;
    heat = keep_heat;
    @(negedge clock);
    unload = 0;
  endtask

  initial begin
    // Preheat timing: heat sampled at edge 0, temp_ok only after edge 4
    do_reset();
    heat = 1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clock);
      chk($sformatf("preheat_edge%0d", k), int'(temp_ok), (k == 4) ? 1 : 0);
    end

    // One full cook cycle, unloading with heat dropped
    load = 1;
    @(negedge clock);
    load = 0;
    chk("cycle_stock_after_load", int'(stock), 1);
    for (int k = 1; k <= COOK; k++) begin
      @(negedge clock);
      chk($sformatf("cook_edge%0d", k), int'(done), (k == COOK) ? 1 : 0);
    end
    unload = 1;
    heat = 0;
    @(negedge clock);
    unload = 0;
    chk("cycle_food_out_pulse", int'(food_out), 1);
    chk("cycle_cold_temp_ok", int'(temp_ok), 0);
    chk("cycle_done_cleared", int'(done), 0);
    @(negedge clock);
    chk("cycle_food_out_single", int'(food_out), 0);
    chk("cycle_fault", int'(fault), 0);
    chk("cycle_stock", int'(stock), 1);

    // Stock exhaustion, then refill with same-cycle load
    do_reset();
    full_cycle(1'b1);
    full_cycle(1'b1);
    chk("exhaust_stock0", int'(stock), 0);
    load = 1;
    @(negedge clock);
    load = 0;
    chk("exhaust_fault", int'(fault), 1);
    chk("exhaust_stock", int'(stock), 0);
    chk("exhaust_empty", int'(empty), 1);
    chk("exhaust_still_hot", int'(temp_ok), 1);
    chk("exhaust_not_done", int'(done), 0);
    refill = 1;
    load = 1;
    @(negedge clock);
    refill = 0;
    load = 0;
    chk("refill_load_stock", int'(stock), 1);
    chk("refill_load_cooking", int'(temp_ok), 1);
    chk("refill_load_empty", int'(empty), 0);

    // Heat dropped three cycles into cooking
    do_reset();
    heat = 1;
    wait_for("drop_wait_temp_ok", 1'b0);
    load = 1;
    @(negedge clock);
    load = 0;
    repeat (3) @(negedge clock);
    heat = 0;
    @(negedge clock);
    chk("drop_fault", int'(fault), 1);
    chk("drop_cold", int'(temp_ok), 0);
    chk("drop_stock", int'(stock), 1);
    repeat (8) @(negedge clock);
    chk("drop_never_done", int'(done), 0);

    // Load while warming; fault_clr loses to a same-cycle violation
    do_reset();
    heat = 1;
    @(negedge clock);
    load = 1;
    @(negedge clock);
    load = 0;
    chk("warm_load_fault", int'(fault), 1);
    chk("warm_load_stock", int'(stock), STK);
    chk("warm_load_temp_ok", int'(temp_ok), 0);
    fault_clr = 1;
    unload = 1;
    @(negedge clock);
    fault_clr = 0;
    unload = 0;
    chk("clr_vs_viol_fault", int'(fault), 1);
    chk("clr_vs_viol_stock", int'(stock), STK);
    fault_clr = 1;
    @(negedge clock);
    fault_clr = 0;
    chk("clr_alone_fault", int'(fault), 0);
    @(negedge clock);
    chk("warm_unperturbed_temp_ok", int'(temp_ok), 1);

    // Asynchronous reset mid-cook, then preheat restarts from zero
    do_reset();
    heat = 1;
    wait_for("areset_wait_temp_ok", 1'b0);
    load = 1;
    @(negedge clock);
    load = 0;
    repeat (2) @(negedge clock);
    #2;
    reset_n = 1'b0;
    heat = 0;
    #1;
    chk("areset_temp_ok", int'(temp_ok), 0);
    chk("areset_done", int'(done), 0);
    chk("areset_food_out", int'(food_out), 0);
    chk("areset_empty", int'(empty), 0);
    chk("areset_stock", int'(stock), STK);
    @(negedge clock);
    reset_n = 1'b1;
    heat = 1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clock);
      chk($sformatf("repreheat_edge%0d", k), int'(temp_ok), (k == 4) ? 1 : 0);
    end
    chk("areset_stock_after", int'(stock), STK);
    heat = 0;
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
